// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_t;

  localparam int MEM_LAT_DEFAULT = 2;
  localparam int CNT_W = $clog2(MEM_LAT_DEFAULT + 1);

  // Width of the wait counter for a given memory latency.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that times a fixed-latency memory access.
module mem_wait_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT  = MEM_LAT_DEFAULT,
  parameter int CNT_W_P  = cnt_width(MEM_LAT)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam logic [CNT_W_P-1:0] LOAD_VAL = CNT_W_P'(MEM_LAT - 1);

  logic [CNT_W_P-1:0] cnt_reg;

  // Load at grant, then count down to zero and hold there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= LOAD_VAL;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNT_W_P'(1);
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  input  logic          flush,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
);

  state_t state_reg;
  logic   drop_reg;
  logic   grant_data;
  logic   grant_inst;
  logic   busy;
  logic   cnt_done;

  // Data wins over fetch; a requester acked this cycle holds a stale req.
  assign grant_data = (state_reg == IDLE) && dm_req && !dm_ack;
  assign grant_inst = (state_reg == IDLE) && !grant_data && if_req && !if_ack && !flush;
  assign busy       = (state_reg != IDLE);

  // Pipeline waits whenever a live request has not yet been acknowledged.
  assign stall = (dm_req && !dm_ack) || (if_req && !if_ack && !flush);

  mem_wait_counter #(
    .MEM_LAT (MEM_LAT),
    .CNT_W_P (cnt_width(MEM_LAT))
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (grant_data || grant_inst),
    .dec  (busy),
    .done (cnt_done)
  );

  // Access sequencer: grant, hold the memory interface, then return data and ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      drop_reg  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_data) begin
            state_reg <= DATA;
            mem_en    <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (grant_inst) begin
            state_reg <= INST;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
          end
        end
        DATA: begin
          if (cnt_done) begin
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
            dm_ack    <= 1'b1;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            state_reg <= IDLE;
          end
        end
        INST: begin
          if (cnt_done) begin
            // A flush seen at any point of the fetch makes its result wrong-path.
            if (!(drop_reg || flush)) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
            drop_reg  <= 1'b0;
            mem_en    <= 1'b0;
            state_reg <= IDLE;
          end else if (flush) begin
            drop_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter at MEM_LAT=2.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, flush;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, mem_en, mem_we, stall;

  typedef struct {
    logic [31:0] data;
    int          cycle;
  } exp_t;

  exp_t dq[$];
  exp_t iq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   c0;

  mem_port_arbiter #(.MEM_LAT(2), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .flush     (flush),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  // Advance one cycle, sample 1ns after the edge and settle scoreboard acks.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (dq.size() > 0 && dq[0].cycle == cyc) begin
      chk("dm_ack", 32'(dm_ack), 32'd1);
      chk("dm_rdata", dm_rdata, dq[0].data);
      void'(dq.pop_front());
    end else begin
      chk("dm_ack_quiet", 32'(dm_ack), 32'd0);
    end
    if (iq.size() > 0 && iq[0].cycle == cyc) begin
      chk("if_ack", 32'(if_ack), 32'd1);
      chk("if_rdata", if_rdata, iq[0].data);
      void'(iq.pop_front());
    end else begin
      chk("if_ack_quiet", 32'(if_ack), 32'd0);
    end
    $display("cycle %0d: mem_en=%b mem_we=%b mem_addr=%h dm_ack=%b if_ack=%b stall=%b",
             cyc, mem_en, mem_we, mem_addr, dm_ack, if_ack, stall);
  endtask

  initial begin
    rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; flush = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    step();
    chk("rst_state", 32'(dut.state_reg), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    rst = 1'b0;
    step();

    // 1. Reset in the middle of a data read abandons it.
    dm_req = 1; dm_we = 0; dm_addr = 32'h10; mem_rdata = 32'hAAAA0000;
    step();
    chk("t1_mem_en_before_rst", 32'(mem_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t1_state", 32'(dut.state_reg), 32'd0);
    chk("t1_mem_en", 32'(mem_en), 32'd0);
    chk("t1_dm_ack", 32'(dm_ack), 32'd0);
    rst = 1'b0; dm_req = 0;
    repeat (4) step();
    chk("t1_dm_rdata", dm_rdata, 32'd0);

    // 2. Plain fetch.
    c0 = cyc;
    if_req = 1; if_addr = 32'h40; mem_rdata = 32'h00500093;
    iq.push_back('{32'h00500093, c0 + 3});
    #1 chk("t2_stall_c0", 32'(stall), 32'd1);
    step();
    chk("t2_mem_en_c1", 32'(mem_en), 32'd1);
    chk("t2_mem_addr", mem_addr, 32'h40);
    chk("t2_stall_c1", 32'(stall), 32'd1);
    step();
    chk("t2_mem_en_c2", 32'(mem_en), 32'd1);
    chk("t2_stall_c2", 32'(stall), 32'd1);
    step();
    chk("t2_mem_en_c3", 32'(mem_en), 32'd0);
    chk("t2_stall_c3", 32'(stall), 32'd0);
    if_req = 0;
    step();

    // 3. Collision: data first, fetch granted in the dm_ack cycle.
    c0 = cyc;
    dm_req = 1; dm_we = 0; dm_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h44;
    dq.push_back('{32'hDEADBEEF, c0 + 3});
    iq.push_back('{32'h11111111, c0 + 6});
    step();
    chk("t3_mem_addr_data", mem_addr, 32'h100);
    chk("t3_mem_we", 32'(mem_we), 32'd0);
    step();
    step();
    chk("t3_stall_c3", 32'(stall), 32'd1);
    dm_req = 0; mem_rdata = 32'h11111111;
    step();
    chk("t3_mem_en_c4", 32'(mem_en), 32'd1);
    chk("t3_mem_addr_inst", mem_addr, 32'h44);
    step();
    step();
    if_req = 0;
    step();

    // 4. Data write leaves dm_rdata alone.
    c0 = cyc;
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h12345678; mem_rdata = 32'hBAD0BAD0;
    dq.push_back('{32'hDEADBEEF, c0 + 3});
    step();
    chk("t4_mem_we_c1", 32'(mem_we), 32'd1);
    chk("t4_mem_addr", mem_addr, 32'h200);
    chk("t4_mem_wdata", mem_wdata, 32'h12345678);
    step();
    chk("t4_mem_we_c2", 32'(mem_we), 32'd1);
    step();
    chk("t4_mem_we_c3", 32'(mem_we), 32'd0);
    dm_req = 0; dm_we = 0;
    step();

    // 5. Flush during a fetch drops it; the redirected fetch follows.
    c0 = cyc;
    if_req = 1; if_addr = 32'h60; mem_rdata = 32'hCAFEF00D;
    step();
    flush = 1;
    #1 chk("t5_stall_flush", 32'(stall), 32'd0);
    step();
    chk("t5_drop", 32'(dut.drop_reg), 32'd1);
    flush = 0; if_addr = 32'h80; mem_rdata = 32'h00000013;
    iq.push_back('{32'h00000013, c0 + 6});
    step();
    chk("t5_drop_clear", 32'(dut.drop_reg), 32'd0);
    chk("t5_mem_en_c3", 32'(mem_en), 32'd0);
    chk("t5_if_rdata_kept", if_rdata, 32'h11111111);
    step();
    chk("t5_mem_en_c4", 32'(mem_en), 32'd1);
    chk("t5_mem_addr", mem_addr, 32'h80);
    step();
    step();
    if_req = 0;
    step();

    // 6. Request held through its ack cycle is not re-granted there.
    c0 = cyc;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300; mem_rdata = 32'h55AA55AA;
    dq.push_back('{32'h55AA55AA, c0 + 3});
    step();
    step();
    step();
    dm_addr = 32'h304; mem_rdata = 32'h77777777;
    dq.push_back('{32'h77777777, c0 + 7});
    step();
    chk("t6_no_regrant", 32'(mem_en), 32'd0);
    step();
    chk("t6_regrant", 32'(mem_en), 32'd1);
    chk("t6_mem_addr", mem_addr, 32'h304);
    step();
    step();
    dm_req = 0;
    repeat (3) step();

    chk("dq_drained", 32'(dq.size()), 32'd0);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
